mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port memory between the pipeline's instruction-fetch port and its MEM-stage data port. It serialises the two requesters with data-first priority and drives a ready/ack handshake to the memory. It buffers the returned words and raises a pipeline-wide stall until every access the current cycle needs has completed. It sits between the 5-stage datapath's `inst_*`/`mem_*` ports and the unified RAM.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `clk`  in  1: single clock; all state on rising edge.
- `cpu_rst_n`  in  1: asynchronous, active-low reset.
- `cpu_en`  in  1: pipeline enable. Low blocks new issues and holds done flags.
- `inst_ren`  in  1: fetch request from IF.
- `inst_addr`  in  AW: fetch address.
- `inst_data`  out  DW: fetched word (buffered).
- `mem_ren`, `mem_wen`  in  1 each: MEM-stage read/write request. Never both high.
- `mem_addr`  in  AW: data address.
- `mem_dout`  in  DW: store data from datapath.
- `mem_din`  out  DW: load data to datapath (buffered).
- `pipe_stall`  out  1: freeze all pipeline registers and PC.
- `ram_req`  out  1: memory request, registered.
- `ram_we`  out  1: write strobe qualifying `ram_req`.
- `ram_addr`  out  AW: latched address.
- `ram_wdata`  out  DW: latched store data.
- `ram_rdata`  in  DW: read data, valid with `ram_ack`.
- `ram_ack`  in  1: access complete. Ignored while `ram_req`=0.

## Operation
- Flags: `d_done`, `i_done`, both 1-bit.
  - `pend_d` = (`mem_ren`|`mem_wen`) & ~`d_done`
  - `pend_i` = `inst_ren` & ~`i_done`
- `pipe_stall` = `pend_d` | `pend_i`. This is combinational from the request inputs and the flags.
- FSM states: IDLE, DATA, INST.
- IDLE, with `cpu_en`=1:
  - If `pend_d`: latch `mem_addr`, `mem_dout`, and `ram_we`=`mem_wen`; go to DATA.
  - Else if `pend_i`: latch `inst_addr` with `ram_we`=0; go to INST.
  - Else stay in IDLE.
- DATA/INST: `ram_req`=1. Address and data stay frozen until an edge samples `ram_ack`=1.
- On ack in DATA:
  - Set `d_done`.
  - If the access was a read, load `ram_rdata` into the `mem_din` buffer.
  - Choose the next state with the IDLE rule, treating data as done. This gives back-to-back INST when `pend_i`.
- On ack in INST:
  - Load `ram_rdata` into the `inst_data` buffer and set `i_done`.
  - Go to IDLE.
- Advance: on an edge where `cpu_en`=1 and `pipe_stall`=0, clear both flags.
- Priority is fixed: data before instruction. The older instruction in MEM always completes first.
- Requesters hold address, data and enables stable while `pipe_stall`=1. The arbiter latches at issue, so later input changes do not affect an in-flight access.
- With `cpu_en`=0:
  - No issue from IDLE.
  - An in-flight access still completes and captures its data.
  - Flags are neither cleared nor changed except by that capture.
- A request that drops while its access is in flight still completes. The data is captured and the flag is set, but it has no effect until the next advance clears the flag.

## Timing
- Reset values:
  - State IDLE.
  - `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `inst_data`=0, `mem_din`=0.
  - `d_done`=`i_done`=0.
  - `pipe_stall` then follows its equation.
- Reset is asynchronous. Asserting it mid-access drops `ram_req` immediately and abandons the access. The memory must tolerate the abandonment.
- Issue latency: a request seen in IDLE at edge N gives `ram_req`=1 in cycle N+1.
- The earliest ack is in the same cycle as `ram_req`=1 (zero-wait memory).
- Fetch only, zero-wait: `pipe_stall` is high for 2 cycles, then low for 1 cycle, and the pipeline advances at that edge. Each wait-state adds 1 stall cycle.
- Fetch plus load, zero-wait: DATA, then INST back-to-back.
  - `pipe_stall` is high for 3 cycles.
  - `ram_req` is high for 2 consecutive cycles, the first with `ram_we`=0 on the data address.
- `inst_data`/`mem_din` are valid from the cycle after capture and hold until the next capture.

## Test plan
- Reset with `inst_ren`=1 and `inst_addr`=0x0, zero-wait memory returning 0x2008_0005 -> `ram_req` in cycle 1, `pipe_stall` high for cycles 0–1, `inst_data`=0x2008_0005 in cycle 2, stall low in cycle 2.
- Fetch 0x4 and `lw` from 0x100 simultaneously (RAM[0x100]=0xDEAD_BEEF) -> data issued first, INST follows back-to-back, `mem_din`=0xDEAD_BEEF, stall high for exactly 3 cycles.
- `sw` 0x1234_5678 to 0x80 with `ram_ack` delayed 3 cycles, changing `mem_dout` to 0 during the wait -> `ram_we`=1, `ram_wdata` stays 0x1234_5678, stall high for 5 cycles, no `mem_din` change.
- Drop `cpu_en` while INST is in flight -> access completes and `inst_data` updates. The flags are not cleared and there is no new issue until `cpu_en`=1.
- Assert `cpu_rst_n`=0 between edges during DATA -> `ram_req` falls in that cycle, all outputs at reset values, a clean fetch follows afterwards.
- 100 random fetch/load/store mixes with random 0–4 wait-states against a reference model -> every word is correct, there is never more than one `ram_req` outstanding, and no access is issued twice within one stall window.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/ack bus between the arbiter and the unified RAM.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and the MEM stage,
// data first, with buffered read words and a pipeline-wide stall.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          cpu_rst_n,
    input  logic          cpu_en,
    input  logic          inst_ren,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_data,
    input  logic          mem_ren,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic [DW-1:0] mem_din,
    output logic          pipe_stall,
    mem_arbiter_if.master ram
);
    typedef enum logic [1:0] {IDLE, DATA, INST} state_t;
    state_t state, state_nx;
    logic d_done, i_done, pend_d, pend_i, ack, issue_d, issue_i;
    always_comb begin
        pend_d = (mem_ren | mem_wen) & ~d_done;
        pend_i = inst_ren & ~i_done;
        pipe_stall = pend_d | pend_i;
        ack = ram.req & ram.ack;
        issue_d = 1'b0;
        issue_i = 1'b0;
        if (state == IDLE) begin
            issue_d = cpu_en & pend_d;
            issue_i = cpu_en & ~pend_d & pend_i;
        end else if (state == DATA && ack) begin
            // a completing data access hands straight over to a waiting fetch
            issue_i = cpu_en & pend_i;
        end
        state_nx = issue_d ? DATA : issue_i ? INST : ack ? IDLE : state;
    end
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            ram.req   <= 1'b0;
            ram.we    <= 1'b0;
            ram.addr  <= '0;
            ram.wdata <= '0;
            inst_data <= '0;
            mem_din   <= '0;
            d_done    <= 1'b0;
            i_done    <= 1'b0;
        end else begin
            state   <= state_nx;
            ram.req <= state_nx != IDLE;
            if (issue_d) begin
                ram.addr  <= mem_addr;
                ram.wdata <= mem_dout;
                ram.we    <= mem_wen;
            end else if (issue_i) begin
                ram.addr <= inst_addr;
                ram.we   <= 1'b0;
            end
            if (cpu_en && !pipe_stall) begin
                d_done <= 1'b0;
                i_done <= 1'b0;
            end
            // a capture wins over a simultaneous advance so a late completion is never lost
            if (ack && state == DATA) begin
                d_done <= 1'b1;
                if (!ram.we) mem_din <= ram.rdata;
            end
            if (ack && state == INST) begin
                i_done    <= 1'b1;
                inst_data <= ram.rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a word-level
// memory model, with a scoreboard popped whenever the pipeline would advance.
module tb_mem_arbiter;
    logic clk = 1'b0, cpu_rst_n = 1'b0, cpu_en = 1'b1;
    logic inst_ren = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [31:0] inst_addr = '0, mem_addr = '0, mem_dout = '0;
    logic [31:0] inst_data, mem_din;
    logic pipe_stall;

    mem_arbiter_if #(.AW(32), .DW(32)) ram ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .pipe_stall(pipe_stall),
        .ram(ram)
    );

    always #5 clk = ~clk;

    typedef struct { bit i, r, w; logic [31:0] ia, da, wd, ei, ed; } txn_t;
    typedef struct { bit we; logic [31:0] a, wd; } acc_t;
    txn_t sb_q[$];
    acc_t acc_q[$];
    txn_t mt;
    int mn, mk;
    logic [31:0] ref_mem [256];
    logic [31:0] ram_mem [256];
    bit [255:0] written;
    logic [31:0] exp_inst = '0, exp_din = '0;
    int n_tests = 0, n_fail = 0, waited = 0, wreq = 0;

    function automatic logic [31:0] init_word(input int j);
        return j == 0 ? 32'h2008_0005 : j == 64 ? 32'hDEAD_BEEF :
               32'hA5A5_0000 ^ (32'(j) * 32'h0001_0103);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM: acks after wreq wait cycles, logs every completed access
    assign ram.ack = ram.req && waited >= wreq;
    assign ram.rdata = written[ram.addr[9:2]] ? ram_mem[ram.addr[9:2]] : init_word(int'(ram.addr[9:2]));

    initial forever begin
        @(posedge clk);
        if (ram.req && ram.ack) begin
            acc_q.push_back('{ram.we, ram.addr, ram.wdata});
            if (ram.we) begin
                ram_mem[ram.addr[9:2]] = ram.wdata;
                written[ram.addr[9:2]] = 1'b1;
            end
            waited <= 0;
        end else begin
            waited <= ram.req ? waited + 1 : 0;
        end
    end

    // monitor: the pipeline advances here, so the window's accesses and buffers must be final
    initial forever begin
        @(negedge clk);
        if (cpu_rst_n && cpu_en && !pipe_stall && sb_q.size() > 0) begin
            mt = sb_q.pop_front();
            mn = int'(mt.r | mt.w) + int'(mt.i);
            chk("acc_count", acc_q.size(), mn);
            if (acc_q.size() == mn) begin
                mk = 0;
                if (mt.r | mt.w) begin
                    chk("d_we", acc_q[0].we, mt.w);
                    chk("d_addr", acc_q[0].a, mt.da);
                    if (mt.w) chk("d_wdata", acc_q[0].wd, mt.wd);
                    mk = 1;
                end
                if (mt.i) begin
                    chk("i_we", acc_q[mk].we, 0);
                    chk("i_addr", acc_q[mk].a, mt.ia);
                end
            end
            acc_q.delete();
            chk("inst_data", inst_data, mt.ei);
            chk("mem_din", mem_din, mt.ed);
        end
    end

    task automatic issue(input bit i, input logic [31:0] ia, input bit r, input bit w,
                         input logic [31:0] da, input logic [31:0] wd, input int wt,
                         output int stalls, output logic [31:0] tr);
        bit done;
        inst_ren = i; inst_addr = ia; mem_ren = r; mem_wen = w;
        mem_addr = da; mem_dout = wd; wreq = wt;
        // the MEM-stage access is older than the fetch, so it takes effect first
        if (r) exp_din = ref_mem[da[9:2]];
        if (w) ref_mem[da[9:2]] = wd;
        if (i) exp_inst = ref_mem[ia[9:2]];
        sb_q.push_back('{i:i, r:r, w:w, ia:ia, da:da, wd:wd, ei:exp_inst, ed:exp_din});
        stalls = 0;
        tr = '0;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (c < 32) tr[c] = ram.req;
            if (!pipe_stall && cpu_en) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: pipe_stall still %b after 80 cycles, expected 0", pipe_stall);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s, k;
        logic [31:0] tr;
        for (int j = 0; j < 256; j++) ref_mem[j] = init_word(j);
        inst_ren = 1'b1;
        inst_addr = '0;
        #3;
        chk("rst_req", ram.req, 0);
        chk("rst_we", ram.we, 0);
        chk("rst_addr", ram.addr, 0);
        chk("rst_wdata", ram.wdata, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_stall", pipe_stall, 1);
        repeat (2) @(posedge clk);
        #1;
        cpu_rst_n = 1'b1;

        issue(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, s, tr);
        chk("t1_stall_cycles", s, 2);
        chk("t1_req_c0", tr[0], 0);
        chk("t1_req_c1", tr[1], 1);

        issue(1, 32'h4, 1, 0, 32'h100, 32'h0, 0, s, tr);
        chk("t2_stall_cycles", s, 3);
        chk("t2_req_trace", tr[3:0], 4'b0110);
        chk("t2_mem_din", mem_din, 32'hDEAD_BEEF);

        fork
            issue(0, 32'h0, 0, 1, 32'h80, 32'h1234_5678, 3, s, tr);
            begin
                repeat (2) @(negedge clk);
                mem_dout = '0;
            end
        join
        chk("t3_stall_cycles", s, 5);
        chk("t3_req_trace", tr[5:0], 6'b011110);
        chk("t3_mem_din_hold", mem_din, 32'hDEAD_BEEF);

        fork
            issue(1, 32'h8, 0, 0, 32'h0, 32'h0, 2, s, tr);
            begin
                repeat (2) @(negedge clk);
                cpu_en = 1'b0;
                repeat (4) @(negedge clk);
                chk("t4_inst_capture", inst_data, ref_mem[2]);
                chk("t4_flag_held", pipe_stall, 0);
                chk("t4_no_issue", ram.req, 0);
                repeat (2) @(negedge clk);
                chk("t4_no_issue_late", ram.req, 0);
                chk("t4_flag_held_late", pipe_stall, 0);
                @(posedge clk);
                #1;
                cpu_en = 1'b1;
            end
        join

        mem_ren = 1'b1; mem_addr = 32'h40; inst_ren = 1'b0; wreq = 4;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("t5_req_in_data", ram.req, 1);
        cpu_rst_n = 1'b0;
        #1;
        chk("t5_req_drop", ram.req, 0);
        chk("t5_we", ram.we, 0);
        chk("t5_addr", ram.addr, 0);
        chk("t5_wdata", ram.wdata, 0);
        chk("t5_inst_data", inst_data, 0);
        chk("t5_mem_din", mem_din, 0);
        mem_ren = 1'b0;
        @(posedge clk);
        #1;
        cpu_rst_n = 1'b1;
        exp_inst = '0;
        exp_din = '0;
        issue(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, s, tr);
        chk("t5_refetch_stall", s, 2);

        for (int n = 0; n < 100; n++) begin
            k = int'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2, k == 1, k == 2,
                  32'($urandom_range(0, 31)) << 2, $urandom, int'($urandom_range(0, 4)), s, tr);
        end
        issue(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, s, tr);
        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
